// File: rtl/acondicionador_pulsador_if.sv
// Push-button conditioner signal bundle: raw pin in, clean events and diagnostics out.
interface acondicionador_pulsador_if;
  logic       boton_raw;
  logic       pulso_real;
  logic       presionado;
  logic       pulso_largo;
  logic [7:0] rebotes;

  modport slave (
    input  boton_raw,
    output pulso_real,
    output presionado,
    output pulso_largo,
    output rebotes
  );

  modport master (
    output boton_raw,
    input  pulso_real,
    input  presionado,
    input  pulso_largo,
    input  rebotes
  );
endinterface

// File: rtl/acondicionador_pulsador.sv
// Push-button conditioner: 2-flop synchroniser, debounce FSM, press edge,
// long-press event and a saturating count of aborted confirmations.
module acondicionador_pulsador #(
  parameter logic [31:0] CICLOS_MS   = 32'd50000,
  parameter logic [31:0] ESTABLE_MS  = 32'd20,
  parameter logic [31:0] LARGO_MS    = 32'd1000,
  parameter logic        ACTIVO_BAJO = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  acondicionador_pulsador_if.slave    bus
);

  localparam logic [31:0] D = ESTABLE_MS * CICLOS_MS;
  localparam logic [31:0] L = LARGO_MS * CICLOS_MS;

  typedef enum logic [1:0] {
    SUELTO       = 2'd0,
    CONF_PRESION = 2'd1,
    PRESIONADO   = 2'd2,
    CONF_SUELTA  = 2'd3
  } estado_t;

  logic [1:0]  r_sync;
  logic        w_b;
  estado_t     r_estado;
  logic [31:0] r_cnt;
  logic [31:0] r_hold;
  logic        r_largo_hecho;
  logic        r_pulso_real;
  logic        r_pulso_largo;
  logic        r_presionado;
  logic [7:0]  r_rebotes;
  logic        w_en_presion;

  // Idle level of the pin is the not-pressed level, so reset loads ACTIVO_BAJO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= {2{ACTIVO_BAJO}};
    end else begin
      r_sync <= {r_sync[0], bus.boton_raw};
    end
  end

  assign w_b          = r_sync[1] ^ ACTIVO_BAJO;
  assign w_en_presion = (r_estado == PRESIONADO) || (r_estado == CONF_SUELTA);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_estado      <= SUELTO;
      r_cnt         <= 32'd0;
      r_hold        <= 32'd0;
      r_largo_hecho <= 1'b0;
      r_pulso_real  <= 1'b0;
      r_pulso_largo <= 1'b0;
      r_presionado  <= 1'b0;
      r_rebotes     <= 8'd0;
    end else begin
      r_pulso_real  <= 1'b0;
      r_pulso_largo <= 1'b0;

      // Long-press timer sits before the FSM so a release entering SUELTO
      // on the same edge still wins the clear of largo_hecho.
      if (w_en_presion) begin
        r_hold <= r_hold + 32'd1;
        if ((r_hold == L - 32'd1) && !r_largo_hecho) begin
          r_pulso_largo <= 1'b1;
          r_largo_hecho <= 1'b1;
        end
      end

      case (r_estado)
        SUELTO: begin
          if (w_b) begin
            r_estado <= CONF_PRESION;
            r_cnt    <= 32'd0;
          end
        end
        CONF_PRESION: begin
          if (!w_b) begin
            r_estado      <= SUELTO;
            r_cnt         <= 32'd0;
            r_largo_hecho <= 1'b0;
            if (r_rebotes != 8'hFF) r_rebotes <= r_rebotes + 8'd1;
          end else if (r_cnt == D - 32'd1) begin
            r_estado     <= PRESIONADO;
            r_cnt        <= 32'd0;
            r_pulso_real <= 1'b1;
            r_presionado <= 1'b1;
            r_hold       <= 32'd0;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        PRESIONADO: begin
          if (!w_b) begin
            r_estado <= CONF_SUELTA;
            r_cnt    <= 32'd0;
          end
        end
        CONF_SUELTA: begin
          // A bounced release returns to PRESIONADO without touching r_hold.
          if (w_b) begin
            r_estado <= PRESIONADO;
            r_cnt    <= 32'd0;
            if (r_rebotes != 8'hFF) r_rebotes <= r_rebotes + 8'd1;
          end else if (r_cnt == D - 32'd1) begin
            r_estado      <= SUELTO;
            r_cnt         <= 32'd0;
            r_presionado  <= 1'b0;
            r_largo_hecho <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        default: begin
          r_estado <= SUELTO;
          r_cnt    <= 32'd0;
        end
      endcase
    end
  end

  assign bus.pulso_real  = r_pulso_real;
  assign bus.pulso_largo = r_pulso_largo;
  assign bus.presionado  = r_presionado;
  assign bus.rebotes     = r_rebotes;

endmodule
